accum_drain_pool: RTL and testbench
===================================

Name: accum_drain_pool

Overview:
- Downstream stage of the 4-channel convolve-accumulate block.
- Once the last input-channel group has been accumulated, it drains the float32 partial-sum buffer through the buffer's second read port.
- It applies optional ReLU and optional 2x2/stride-2 max pooling, then streams results out on a valid/ready interface to the next layer's input store.
- One run drains one output feature map of row_in x col_in words, stored row-major from address 0.

Parameters:
- DataWidth, 32, float32 word width (IEEE-754 single).
- MaxRowWidth, 9, width of row dimension inputs.
- MaxColWidth, 9, width of column dimension inputs.
- AddrWidth, 16, accumulation buffer address width.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a drain run (ignored while busy).
- row_in  in  MaxRowWidth  feature-map rows; latched at start.
- col_in  in  MaxColWidth  feature-map columns; latched at start.
- relu_en  in  1  apply ReLU; latched at start.
- pool_en  in  1  apply 2x2 max pool; latched at start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final output is accepted.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  AddrWidth  buffer read address.
- rd_data  in  DataWidth  read data, valid exactly 1 cycle after rd_en.
- out_data  out  DataWidth  result word.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer ready.
- out_last  out  1  high with the final result of the run.

Behaviour:
- Reset: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_last=0, out_data=0. FSM goes to IDLE; all counters cleared.
- Reset mid-run aborts the run immediately; no done pulse is produced.
- FSM states: IDLE, FETCH, COLLECT, OUT, FIN.
- IDLE:
  - On start, latch row_in, col_in, relu_en and pool_en.
  - Compute group count G:
    - pool_en=1: G = floor(row/2) * floor(col/2). An odd trailing row or column is dropped.
    - pool_en=0: G = row * col.
  - G=0 -> FIN. Otherwise -> FETCH.
- FETCH:
  - Issue N reads on N consecutive cycles, rd_en=1 each cycle. N=4 when pooling, N=1 otherwise.
  - Pool read order for group (r,c), with r and c even: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  - Address = r*col + c, generated by incremental adders (row base address plus offset); no multiplier.
  - Non-pool reads run linearly 0..row*col-1.
  - rd_en is 0 in every other state.
- COLLECT:
  - Runs for one cycle after the last read. The data for each read is folded in as it returns:
    - acc = first word.
    - acc = fmax(acc, word) for each later word.
  - The cycle the final word arrives, register out_data = relu_en ? relu(acc_final) : acc_final. Assert out_valid and go to OUT.
  - Latency: first rd_en cycle to out_valid = N+1 cycles.
- OUT:
  - Hold out_data, out_valid and out_last stable until out_valid & out_ready.
  - On that handshake: out_valid drops next cycle. If this was the last group -> FIN, else -> FETCH on the next cycle.
  - out_last=1 only with group G-1.
- FIN: done=1 for one cycle, busy=0 -> IDLE. When G=0, done pulses the cycle after start.
- busy is high through FETCH, COLLECT and OUT.
- fmax:
  - IEEE total-order compare, implemented as an integer compare after sign-magnitude mapping.
  - -0 and +0 are treated as equal; on ties the earlier word is kept.
  - NaN is out of contract.
- relu: sign bit set -> 32'h00000000; otherwise pass through. -0 maps to +0.
- start asserted while busy is ignored.
- out_ready asserted while out_valid=0 has no effect.
- Throughput: one result per N+2 cycles at best. No overlap is required.

Decomposition:
- Shared package contains:
  - fp32 type alias.
  - FP_ZERO constant.
  - Functions fp_max (total-order maximum) and fp_relu.
  - State encoding for the FSM.
- One natural sub-module, pool_addr_gen. It owns the r/c/row-base counters, generates the N addresses per group, and produces the last-group flag.

Test Plan:
- Non-pool, ReLU on, 1x3 map, buffer = {3F800000, C0000000, 40400000}:
  - Outputs 3F800000, 00000000, 40400000; out_last on the third.
  - done one cycle after the third handshake.
- Pool on, ReLU off, 2x2 map, buffer = {C0000000, BF800000, C0400000, C0800000}:
  - Single output BF800000 (-1.0) with out_last.
  - rd_addr sequence 0, 1, 2, 3.
- Pool on, 3x5 map (odd dims):
  - G=2 groups.
  - Addresses 0, 1, 5, 6, then 2, 3, 7, 8.
  - Row 2 and column 4 are never read.
- Backpressure: out_ready held low 5 cycles while out_valid=1:
  - out_data stable, no rd_en issued.
  - The next group's FETCH starts the cycle after out_ready rises.
- Degenerate and illegal starts:
  - start with col_in=1 and pool_en=1: done pulses next cycle, no rd_en, no out_valid.
  - A second start while busy is ignored.
- Rst asserted mid-OUT:
  - All outputs return to 0 next cycle, no done pulse.
  - A fresh start then runs a full drain correctly.

Source files
------------

// File: rtl/accum_drain_pool_pkg.sv
// Shared float32 helpers and FSM encoding for the accumulator drain / pooling stage.
package accum_drain_pool_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ZERO = 32'h0000_0000;

    // Reads per output group when 2x2 pooling is enabled.
    localparam int POOL_READS = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_OUT     = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    // Map sign-magnitude onto an unsigned key so an integer compare gives float order;
    // both zeros share one key so they compare equal.
    function automatic logic [31:0] fp_order_key(input fp32_t x);
        if (x[30:0] == 31'd0) begin
            return 32'h8000_0000;
        end else if (x[31]) begin
            return ~x;
        end else begin
            return {1'b1, x[30:0]};
        end
    endfunction

    // On ties the first operand (the earlier word) wins.
    function automatic fp32_t fp_max(input fp32_t a, input fp32_t b);
        return (fp_order_key(b) > fp_order_key(a)) ? b : a;
    endfunction

    function automatic fp32_t fp_relu(input fp32_t x);
        return x[31] ? FP_ZERO : x;
    endfunction

endpackage

// File: rtl/accum_drain_pool_if.sv
// Buffer read port and result stream bundled for the drain stage.
interface accum_drain_pool_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 16
);
    logic                 rd_en;
    logic [AddrWidth-1:0] rd_addr;
    logic [DataWidth-1:0] rd_data;
    logic [DataWidth-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output rd_en, rd_addr, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_data, out_valid, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/accum_drain_pool_pool_addr_gen.sv
// Address walker for the drain: row/column/row-base counters, per-group read index
// and last-group detection, built from adders only.
module pool_addr_gen
    import accum_drain_pool_pkg::*;
#(
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9,
    parameter int AddrWidth   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   init,
    input  logic [MaxRowWidth-1:0] row_in,
    input  logic [MaxColWidth-1:0] col_in,
    input  logic                   pool_in,
    input  logic                   fetch,
    input  logic                   advance,
    output logic [AddrWidth-1:0]   rd_addr,
    output logic                   first_read,
    output logic                   last_read,
    output logic                   group_last
);
    localparam int RW = MaxRowWidth + 2;
    localparam int CW = MaxColWidth + 2;

    logic [MaxRowWidth-1:0] row_q, row_d;
    logic [MaxColWidth-1:0] col_q, col_d;
    logic                   pool_q, pool_d;
    logic [1:0]             k_q, k_d;
    logic [RW-1:0]          r_q, r_d;
    logic [CW-1:0]          c_q, c_d;
    logic [AddrWidth-1:0]   row_base_q, row_base_d;

    logic [RW-1:0]        step_r, step2_r;
    logic [CW-1:0]        step_c, step2_c;
    logic [AddrWidth-1:0] row_step;
    logic                 last_row, last_col;

    always_comb begin
        step_r   = pool_q ? RW'(2) : RW'(1);
        step2_r  = pool_q ? RW'(4) : RW'(2);
        step_c   = pool_q ? CW'(2) : CW'(1);
        step2_c  = pool_q ? CW'(4) : CW'(2);
        row_step = pool_q ? AddrWidth'({col_q, 1'b0}) : AddrWidth'(col_q);
        // A group is the last along an axis when one more step would run past the edge;
        // this also drops an odd trailing row/column in pool mode.
        last_row   = (r_q + step2_r) > RW'(row_q);
        last_col   = (c_q + step2_c) > CW'(col_q);
        group_last = last_row & last_col;
        first_read = (k_q == 2'd0);
        last_read  = !pool_q || (k_q == 2'(POOL_READS - 1));
        // Pool order (r,c),(r,c+1),(r+1,c),(r+1,c+1): k[1] selects the lower row, k[0] the right column.
        rd_addr = row_base_q + AddrWidth'(c_q)
                + (k_q[1] ? AddrWidth'(col_q) : '0)
                + AddrWidth'(k_q[0]);
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        pool_d     = pool_q;
        k_d        = k_q;
        r_d        = r_q;
        c_d        = c_q;
        row_base_d = row_base_q;
        if (init) begin
            row_d      = row_in;
            col_d      = col_in;
            pool_d     = pool_in;
            k_d        = '0;
            r_d        = '0;
            c_d        = '0;
            row_base_d = '0;
        end else begin
            if (fetch) begin
                k_d = last_read ? 2'd0 : k_q + 2'd1;
            end
            if (advance) begin
                if (last_col) begin
                    c_d        = '0;
                    r_d        = r_q + step_r;
                    row_base_d = row_base_q + row_step;
                end else begin
                    c_d = c_q + step_c;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            row_q      <= '0;
            col_q      <= '0;
            pool_q     <= 1'b0;
            k_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            pool_q     <= pool_d;
            k_q        <= k_d;
            r_q        <= r_d;
            c_q        <= c_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/accum_drain_pool.sv
// Drains one float32 partial-sum map, applying optional ReLU and 2x2 max pooling,
// and streams the results over a valid/ready port.
module accum_drain_pool
    import accum_drain_pool_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9,
    parameter int AddrWidth   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [MaxRowWidth-1:0] row_in,
    input  logic [MaxColWidth-1:0] col_in,
    input  logic                   relu_en,
    input  logic                   pool_en,
    output logic                   busy,
    output logic                   done,
    accum_drain_pool_if.master     bus
);
    logic [2:0] state_q, state_d;
    logic       relu_q, relu_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_first_q, rd_first_d;
    fp32_t      acc_q, acc_d;
    fp32_t      out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;

    logic                 accept, g_zero, handshake, advance, rd_en;
    logic                 first_read, last_read, group_last;
    logic [AddrWidth-1:0] rd_addr;
    logic [DataWidth-1:0] rd_word;
    fp32_t                acc_fold;

    assign accept    = (state_q == ST_IDLE) && start;
    assign rd_en     = (state_q == ST_FETCH);
    assign handshake = out_valid_q && bus.out_ready;
    assign advance   = (state_q == ST_OUT) && handshake && !group_last;
    // G is zero exactly when some dimension has no complete step.
    assign g_zero    = pool_en ? ((row_in[MaxRowWidth-1:1] == '0) || (col_in[MaxColWidth-1:1] == '0))
                               : ((row_in == '0) || (col_in == '0));

    pool_addr_gen #(
        .MaxRowWidth (MaxRowWidth),
        .MaxColWidth (MaxColWidth),
        .AddrWidth   (AddrWidth)
    ) u_addr_gen (
        .Clk        (Clk),
        .Rst        (Rst),
        .init       (accept),
        .row_in     (row_in),
        .col_in     (col_in),
        .pool_in    (pool_en),
        .fetch      (rd_en),
        .advance    (advance),
        .rd_addr    (rd_addr),
        .first_read (first_read),
        .last_read  (last_read),
        .group_last (group_last)
    );

    assign rd_word  = bus.rd_data;
    assign acc_fold = rd_first_q ? rd_word : fp_max(acc_q, rd_word);

    always_comb begin
        state_d     = state_q;
        relu_d      = relu_q;
        rd_pend_d   = rd_en;
        rd_first_d  = rd_en && first_read;
        acc_d       = rd_pend_q ? acc_fold : acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    relu_d  = relu_en;
                    state_d = g_zero ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (last_read) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // The final word of the group lands this cycle.
                out_data_d  = relu_q ? fp_relu(acc_fold) : acc_fold;
                out_valid_d = 1'b1;
                out_last_d  = group_last;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = group_last ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            relu_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_first_q  <= 1'b0;
            acc_q       <= FP_ZERO;
            out_data_q  <= FP_ZERO;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            relu_q      <= relu_d;
            rd_pend_q   <= rd_pend_d;
            rd_first_q  <= rd_first_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy          = (state_q == ST_FETCH) || (state_q == ST_COLLECT) || (state_q == ST_OUT);
    assign done          = (state_q == ST_FIN);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_accum_drain_pool.sv
// Directed bench for accum_drain_pool: buffer model, stream monitor and hand-computed vectors.
module tb_accum_drain_pool;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       start = 1'b0;
    logic       relu_en = 1'b0;
    logic       pool_en = 1'b0;
    logic [8:0] row_in = '0;
    logic [8:0] col_in = '0;
    logic       busy, done;

    accum_drain_pool_if #(.DataWidth(32), .AddrWidth(16)) bus();

    accum_drain_pool #(
        .DataWidth(32), .MaxRowWidth(9), .MaxColWidth(9), .AddrWidth(16)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (start),
        .row_in  (row_in),
        .col_in  (col_in),
        .relu_en (relu_en),
        .pool_en (pool_en),
        .busy    (busy),
        .done    (done),
        .bus     (bus.master)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Buffer model: data one cycle after the read strobe.
    logic [31:0] mem [0:255];
    always @(posedge Clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[7:0]];
    end

    // Monitor: log reads, handshakes, valid rises and done pulses with their cycle numbers.
    int          n_rd = 0, n_out = 0, n_done = 0, n_vr = 0;
    logic [31:0] addr_log [128];
    int          rd_cyc   [128];
    logic [31:0] out_log  [32];
    logic        last_log [32];
    int          hs_cyc   [32];
    int          vr_cyc   [32];
    int          done_cyc = 0;
    logic        prev_valid = 1'b0;

    always @(negedge Clk) begin
        if (Rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.rd_en && n_rd < 128) begin
                addr_log[n_rd] = 32'(bus.rd_addr);
                rd_cyc[n_rd]   = cyc;
                n_rd++;
            end
            if (bus.out_valid && !prev_valid && n_vr < 32) begin
                vr_cyc[n_vr] = cyc;
                n_vr++;
            end
            if (bus.out_valid && bus.out_ready && n_out < 32) begin
                out_log[n_out]  = bus.out_data;
                last_log[n_out] = bus.out_last;
                hs_cyc[n_out]   = cyc;
                $display("out  #%0d data=%08h last=%0b cycle=%0d", n_out, bus.out_data, bus.out_last, cyc);
                n_out++;
            end
            if (done) begin
                done_cyc = cyc;
                n_done++;
            end
            prev_valid = bus.out_valid;
        end
    end

    int n_vec = 0, n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %-16s got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %-16s %08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int b_rd, b_out, b_done, b_vr, start_cyc;

    task automatic do_start(input int r, input int c, input logic relu, input logic pool);
        b_rd = n_rd; b_out = n_out; b_done = n_done; b_vr = n_vr;
        row_in = 9'(r); col_in = 9'(c); relu_en = relu; pool_en = pool;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && n_done == b_done; i++) tick();
        check("done_count", 32'(n_done - b_done), 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !bus.out_valid; i++) tick();
        check("valid_seen", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic load_t1();
        mem[0] = 32'h3F80_0000; mem[1] = 32'hC000_0000; mem[2] = 32'h4040_0000;
    endtask

    task automatic check_t1(input string pfx);
        check({pfx, "_nout"}, 32'(n_out - b_out), 32'd3);
        check({pfx, "_out0"}, out_log[b_out],     32'h3F80_0000);
        check({pfx, "_out1"}, out_log[b_out + 1], 32'h0000_0000);
        check({pfx, "_out2"}, out_log[b_out + 2], 32'h4040_0000);
        check({pfx, "_last1"}, 32'(last_log[b_out + 1]), 32'd0);
        check({pfx, "_last2"}, 32'(last_log[b_out + 2]), 32'd1);
        check({pfx, "_donecyc"}, 32'(done_cyc), 32'(hs_cyc[b_out + 2] + 1));
    endtask

    logic [31:0] exp3 [8];
    int          rd_hold;

    initial begin
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) tick();
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_rd_en",     32'(bus.rd_en),     32'd0);
        check("rst_rd_addr",   32'(bus.rd_addr),   32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        Rst = 1'b0;
        tick();

        // 1x3, no pool, ReLU on
        load_t1();
        do_start(1, 3, 1'b1, 1'b0);
        wait_done();
        check_t1("t1");
        check("t1_latency", 32'(vr_cyc[b_vr] - rd_cyc[b_rd]), 32'd2);
        tick();

        // 2x2 pool, ReLU off
        mem[0] = 32'hC000_0000; mem[1] = 32'hBF80_0000; mem[2] = 32'hC040_0000; mem[3] = 32'hC080_0000;
        do_start(2, 2, 1'b0, 1'b1);
        wait_done();
        check("t2_nout", 32'(n_out - b_out), 32'd1);
        check("t2_out",  out_log[b_out], 32'hBF80_0000);
        check("t2_last", 32'(last_log[b_out]), 32'd1);
        for (int i = 0; i < 4; i++) check($sformatf("t2_addr%0d", i), addr_log[b_rd + i], 32'(i));
        check("t2_latency", 32'(vr_cyc[b_vr] - rd_cyc[b_rd]), 32'd5);
        tick();

        // Signed-zero tie keeps the earlier word; ReLU maps it to +0
        mem[0] = 32'h8000_0000; mem[1] = 32'h0000_0000; mem[2] = 32'hBF80_0000; mem[3] = 32'h8000_0000;
        do_start(2, 2, 1'b0, 1'b1);
        wait_done();
        check("tz_out", out_log[b_out], 32'h8000_0000);
        tick();
        do_start(2, 2, 1'b1, 1'b1);
        wait_done();
        check("tz_relu", out_log[b_out], 32'h0000_0000);
        tick();

        // 3x5 pool: trailing row 2 and column 4 are poisoned and must not be read
        for (int i = 0; i < 15; i++) mem[i] = 32'h4000_0000 + 32'(i);
        for (int i = 10; i < 15; i++) mem[i] = 32'h7F00_0000;
        mem[4] = 32'h7F00_0000; mem[9] = 32'h7F00_0000;
        exp3 = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd2, 32'd3, 32'd7, 32'd8};
        do_start(3, 5, 1'b0, 1'b1);
        wait_done();
        check("t3_nrd", 32'(n_rd - b_rd), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("t3_addr%0d", i), addr_log[b_rd + i], exp3[i]);
        check("t3_out0",  out_log[b_out],     32'h4000_0006);
        check("t3_out1",  out_log[b_out + 1], 32'h4000_0008);
        check("t3_last0", 32'(last_log[b_out]),     32'd0);
        check("t3_last1", 32'(last_log[b_out + 1]), 32'd1);
        tick();

        // Backpressure, with an ignored start mid-run
        mem[0] = 32'h3F80_0000; mem[1] = 32'h4000_0000;
        bus.out_ready = 1'b0;
        do_start(1, 2, 1'b1, 1'b0);
        wait_valid();
        rd_hold = n_rd;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                row_in = 9'd5; col_in = 9'd5; pool_en = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            check($sformatf("bp_hold%0d", i), bus.out_data, 32'h3F80_0000);
        end
        start = 1'b0;
        check("bp_busy",  32'(busy), 32'd1);
        check("bp_no_rd", 32'(n_rd - rd_hold), 32'd0);
        bus.out_ready = 1'b1;
        wait_done();
        check("bp_nout",  32'(n_out - b_out), 32'd2);
        check("bp_nrd",   32'(n_rd - b_rd),   32'd2);
        check("bp_out1",  out_log[b_out + 1], 32'h4000_0000);
        check("bp_last1", 32'(last_log[b_out + 1]), 32'd1);
        check("bp_refetch", 32'(rd_cyc[b_rd + 1]), 32'(hs_cyc[b_out] + 1));
        tick();

        // Degenerate pool start: one column
        do_start(4, 1, 1'b0, 1'b1);
        wait_done();
        check("dg_donecyc", 32'(done_cyc), 32'(start_cyc + 1));
        check("dg_nrd",     32'(n_rd - b_rd), 32'd0);
        check("dg_nvalid",  32'(n_vr - b_vr), 32'd0);
        tick();

        // Reset while holding a result
        mem[0] = 32'h3F80_0000; mem[1] = 32'h4000_0000;
        bus.out_ready = 1'b0;
        do_start(1, 2, 1'b0, 1'b0);
        wait_valid();
        Rst = 1'b1;
        tick();
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_out_data",  bus.out_data,       32'd0);
        check("rs_busy",      32'(busy),          32'd0);
        check("rs_rd_en",     32'(bus.rd_en),     32'd0);
        Rst = 1'b0;
        bus.out_ready = 1'b1;
        b_done = n_done;
        repeat (4) tick();
        check("rs_no_done", 32'(n_done - b_done), 32'd0);

        // Fresh run after the abort
        load_t1();
        do_start(1, 3, 1'b1, 1'b0);
        wait_done();
        check_t1("rr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
